// File: rtl/arf_pkg.sv
// Global definitions for the architectural register file block: id/data
// widths, the rename-table entry type and the source-lookup result type.
// Optional feature macro used by arf: ARF_BYPASS_EN.
package arf_pkg;

    localparam int ARF_N_ENTRIES = 32;
    localparam int ROB_N_ENTRIES = 16;
    localparam int DATA_W        = 32;

    localparam int ARF_ID_W = $clog2(ARF_N_ENTRIES);
    localparam int ROB_ID_W = $clog2(ROB_N_ENTRIES);

    typedef logic [ARF_ID_W-1:0] arf_id_t;
    typedef logic [ROB_ID_W-1:0] rob_id_t;
    typedef logic [DATA_W-1:0]   reg_data_t;

    // One rename-table slot: the register's value is pending in the ROB at rob_id.
    typedef struct packed {
        logic    valid;
        rob_id_t rob_id;
    } rat_entry_t;

    // Resolved view of one source operand.
    typedef struct packed {
        logic      renamed;
        rob_id_t   rob_id;
        reg_data_t data;
    } src_out_t;

endpackage

// File: rtl/arf_rat.sv
// Register alias (rename) table: 2 combinational read ports, 1 set port,
// 1 conditional-clear port and a global flush of all valid bits.
// Entry 0 (x0) is never written and always reads as not renamed.
module rat
    import arf_pkg::*;
(
    input  logic       clk,
    input  logic       rst_aL,
    input  arf_id_t    rd1_id,
    output rat_entry_t rd1_entry,
    input  arf_id_t    rd2_id,
    output rat_entry_t rd2_entry,
    input  logic       set_en,
    input  arf_id_t    set_id,
    input  rob_id_t    set_rob_id,
    input  logic       clr_en,
    input  arf_id_t    clr_id,
    input  rob_id_t    clr_rob_id,
    input  logic       flush
);

    rat_entry_t table_q [ARF_N_ENTRIES];

    // Per-entry update priority: flush > dispatch set > matching retire clear.
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            for (int i = 0; i < ARF_N_ENTRIES; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < ARF_N_ENTRIES; i++) begin
                if (flush) begin
                    table_q[i].valid <= 1'b0;
                end else if (set_en && set_id == arf_id_t'(i)) begin
                    table_q[i] <= '{valid: 1'b1, rob_id: set_rob_id};
                end else if (clr_en && clr_id == arf_id_t'(i) &&
                             table_q[i].rob_id == clr_rob_id) begin
                    // A younger mapping (different rob_id) survives the retire.
                    table_q[i].valid <= 1'b0;
                end
            end
        end
    end

    assign rd1_entry = table_q[rd1_id];
    assign rd2_entry = table_q[rd2_id];

endmodule

// File: rtl/arf.sv
// Architectural register file with rename tracking. Holds the committed
// register values and resolves source operands combinationally from the
// registered state. x0 is hard-wired to zero and never renamed.
// Optional feature: define ARF_BYPASS_EN to forward a same-cycle matching
// retire straight to the source outputs instead of pointing at the ROB.
module arf
    import arf_pkg::*;
(
    input  logic      clk,
    input  logic      rst_aL,
    input  logic      retire,
    input  rob_id_t   retire_rob_id,
    input  arf_id_t   retire_arf_id,
    input  reg_data_t retire_reg_data,
    input  logic      dispatch_fire,
    input  logic      dispatch_dst_valid,
    input  arf_id_t   dispatch_dst_arf_id,
    input  rob_id_t   dispatch_rob_id,
    input  arf_id_t   src1_arf_id,
    input  arf_id_t   src2_arf_id,
    output logic      src1_renamed,
    output logic      src2_renamed,
    output rob_id_t   src1_rob_id,
    output rob_id_t   src2_rob_id,
    output reg_data_t src1_reg_data,
    output reg_data_t src2_reg_data,
    input  logic      fetch_redirect_valid
);

    reg_data_t  data_q [ARF_N_ENTRIES];
    rat_entry_t src1_entry;
    rat_entry_t src2_entry;
    logic       rename_set;
    logic       retire_wr;
    logic       src1_byp;
    logic       src2_byp;
    src_out_t   src1_out;
    src_out_t   src2_out;

    assign retire_wr  = retire && (retire_arf_id != '0);
    assign rename_set = dispatch_fire && dispatch_dst_valid && (dispatch_dst_arf_id != '0);

    rat u_rat (
        .clk        (clk),
        .rst_aL     (rst_aL),
        .rd1_id     (src1_arf_id),
        .rd1_entry  (src1_entry),
        .rd2_id     (src2_arf_id),
        .rd2_entry  (src2_entry),
        .set_en     (rename_set),
        .set_id     (dispatch_dst_arf_id),
        .set_rob_id (dispatch_rob_id),
        .clr_en     (retire_wr),
        .clr_id     (retire_arf_id),
        .clr_rob_id (retire_rob_id),
        .flush      (fetch_redirect_valid)
    );

    // Committed data array; a retire is written even when a flush coincides.
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            for (int i = 0; i < ARF_N_ENTRIES; i++) begin
                data_q[i] <= '0;
            end
        end else if (retire_wr) begin
            data_q[retire_arf_id] <= retire_reg_data;
        end
    end

`ifdef ARF_BYPASS_EN
    assign src1_byp = retire_wr && (retire_arf_id == src1_arf_id) &&
                      src1_entry.valid && (src1_entry.rob_id == retire_rob_id);
    assign src2_byp = retire_wr && (retire_arf_id == src2_arf_id) &&
                      src2_entry.valid && (src2_entry.rob_id == retire_rob_id);
`else
    assign src1_byp = 1'b0;
    assign src2_byp = 1'b0;
`endif

    // x0 reads as zero; a bypass hit returns the retiring value; rob_id is
    // forced to zero whenever the operand is not reported as renamed.
    function automatic src_out_t resolve(input arf_id_t    id,
                                         input rat_entry_t e,
                                         input reg_data_t  d,
                                         input logic       byp,
                                         input reg_data_t  byp_data);
        src_out_t r;
        r = '0;
        if (id != '0) begin
            if (byp) begin
                r.data = byp_data;
            end else begin
                r.renamed = e.valid;
                r.rob_id  = e.valid ? e.rob_id : '0;
                r.data    = d;
            end
        end
        return r;
    endfunction

    // Combinational source lookups from the registered state.
    always_comb begin
        src1_out = resolve(src1_arf_id, src1_entry, data_q[src1_arf_id], src1_byp, retire_reg_data);
        src2_out = resolve(src2_arf_id, src2_entry, data_q[src2_arf_id], src2_byp, retire_reg_data);
    end

    assign src1_renamed  = src1_out.renamed;
    assign src1_rob_id   = src1_out.rob_id;
    assign src1_reg_data = src1_out.data;
    assign src2_renamed  = src2_out.renamed;
    assign src2_rob_id   = src2_out.rob_id;
    assign src2_reg_data = src2_out.data;

endmodule

// File: tb/tb_arf.sv
// Self-checking bench for arf: directed scenarios followed by randomized
// traffic, compared against a behavioural register/rename model.
module tb_arf;
    import arf_pkg::*;

    logic      clk = 1'b0;
    logic      rst_aL;
    logic      retire;
    rob_id_t   retire_rob_id;
    arf_id_t   retire_arf_id;
    reg_data_t retire_reg_data;
    logic      dispatch_fire;
    logic      dispatch_dst_valid;
    arf_id_t   dispatch_dst_arf_id;
    rob_id_t   dispatch_rob_id;
    arf_id_t   src1_arf_id;
    arf_id_t   src2_arf_id;
    logic      src1_renamed;
    logic      src2_renamed;
    rob_id_t   src1_rob_id;
    rob_id_t   src2_rob_id;
    reg_data_t src1_reg_data;
    reg_data_t src2_reg_data;
    logic      fetch_redirect_valid;

    int checks = 0;
    int errors = 0;

    // Reference state: committed values and pending-in-ROB mapping per register.
    reg_data_t m_data [ARF_N_ENTRIES];
    logic      m_ren  [ARF_N_ENTRIES];
    rob_id_t   m_rob  [ARF_N_ENTRIES];

    arf dut (
        .clk                  (clk),
        .rst_aL               (rst_aL),
        .retire               (retire),
        .retire_rob_id        (retire_rob_id),
        .retire_arf_id        (retire_arf_id),
        .retire_reg_data      (retire_reg_data),
        .dispatch_fire        (dispatch_fire),
        .dispatch_dst_valid   (dispatch_dst_valid),
        .dispatch_dst_arf_id  (dispatch_dst_arf_id),
        .dispatch_rob_id      (dispatch_rob_id),
        .src1_arf_id          (src1_arf_id),
        .src2_arf_id          (src2_arf_id),
        .src1_renamed         (src1_renamed),
        .src2_renamed         (src2_renamed),
        .src1_rob_id          (src1_rob_id),
        .src2_rob_id          (src2_rob_id),
        .src1_reg_data        (src1_reg_data),
        .src2_reg_data        (src2_reg_data),
        .fetch_redirect_valid (fetch_redirect_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ARF_N_ENTRIES; i++) begin
            m_data[i] = '0;
            m_ren[i]  = 1'b0;
            m_rob[i]  = '0;
        end
    endtask

    // What a lookup of register id must return given the model and current inputs.
    task automatic check_src(input string tag, input arf_id_t id, input logic ren,
                             input rob_id_t rob, input reg_data_t dat);
        logic      e_ren;
        rob_id_t   e_rob;
        reg_data_t e_dat;
        e_ren = 1'b0;
        e_rob = '0;
        e_dat = '0;
        if (id != 0 && rst_aL) begin
            e_ren = m_ren[id];
            e_rob = m_ren[id] ? m_rob[id] : '0;
            e_dat = m_data[id];
`ifdef ARF_BYPASS_EN
            if (retire && retire_arf_id == id && m_ren[id] && m_rob[id] == retire_rob_id) begin
                e_ren = 1'b0;
                e_rob = '0;
                e_dat = retire_reg_data;
            end
`endif
        end
        chk({tag, "_renamed"}, 64'(ren), 64'(e_ren));
        chk({tag, "_rob_id"},  64'(rob), 64'(e_rob));
        chk({tag, "_data"},    64'(dat), 64'(e_dat));
    endtask

    task automatic check_all();
        check_src("src1", src1_arf_id, src1_renamed, src1_rob_id, src1_reg_data);
        check_src("src2", src2_arf_id, src2_renamed, src2_rob_id, src2_reg_data);
    endtask

    // Architectural effect of one clock edge with the current inputs.
    task automatic model_update();
        if (retire && retire_arf_id != 0) begin
            m_data[retire_arf_id] = retire_reg_data;
            if (m_ren[retire_arf_id] && m_rob[retire_arf_id] == retire_rob_id)
                m_ren[retire_arf_id] = 1'b0;
        end
        if (dispatch_fire && dispatch_dst_valid && dispatch_dst_arf_id != 0) begin
            m_ren[dispatch_dst_arf_id] = 1'b1;
            m_rob[dispatch_dst_arf_id] = dispatch_rob_id;
        end
        if (fetch_redirect_valid) begin
            for (int i = 0; i < ARF_N_ENTRIES; i++) m_ren[i] = 1'b0;
        end
    endtask

    task automatic idle();
        retire               = 1'b0;
        retire_rob_id        = '0;
        retire_arf_id        = '0;
        retire_reg_data      = '0;
        dispatch_fire        = 1'b0;
        dispatch_dst_valid   = 1'b0;
        dispatch_dst_arf_id  = '0;
        dispatch_rob_id      = '0;
        fetch_redirect_valid = 1'b0;
    endtask

    task automatic do_retire(input rob_id_t rob, input arf_id_t id, input reg_data_t d);
        retire          = 1'b1;
        retire_rob_id   = rob;
        retire_arf_id   = id;
        retire_reg_data = d;
    endtask

    task automatic do_dispatch(input arf_id_t id, input rob_id_t rob);
        dispatch_fire       = 1'b1;
        dispatch_dst_valid  = 1'b1;
        dispatch_dst_arf_id = id;
        dispatch_rob_id     = rob;
    endtask

    // Called just after a falling edge with inputs applied: check, clock, advance model.
    task automatic step();
        #2;
        check_all();
        @(posedge clk);
        if (rst_aL) model_update();
        @(negedge clk);
    endtask

    initial begin
        idle();
        model_reset();
        rst_aL      = 1'b0;
        src1_arf_id = 5'd5;
        src2_arf_id = 5'd0;
        do_dispatch(5'd5, 4'd3);
        #3;
        chk("reset_x5_renamed", 64'(src1_renamed), 64'd0);
        chk("reset_x5_data",    64'(src1_reg_data), 64'd0);
        @(negedge clk);
        @(negedge clk);
        idle();
        rst_aL = 1'b1;

        // After reset x5 is a plain zero register.
        step();
        chk("post_reset_x5_renamed", 64'(src1_renamed), 64'd0);
        chk("post_reset_x5_data",    64'(src1_reg_data), 64'd0);

        // Dispatch then retire of a single mapping.
        do_dispatch(5'd5, 4'd3);
        step();
        idle();
        #1;
        chk("disp_x5_renamed", 64'(src1_renamed), 64'd1);
        chk("disp_x5_rob_id",  64'(src1_rob_id),  64'd3);
        do_retire(4'd3, 5'd5, 32'hDEAD);
        step();
        idle();
        #1;
        chk("ret_x5_renamed", 64'(src1_renamed),  64'd0);
        chk("ret_x5_data",    64'(src1_reg_data), 64'hDEAD);
        step();

        // Older retire must not drop a younger mapping.
        do_dispatch(5'd5, 4'd3);
        step();
        do_dispatch(5'd5, 4'd7);
        step();
        idle();
        do_retire(4'd3, 5'd5, 32'h1234);
        step();
        idle();
        #1;
        chk("young_x5_renamed", 64'(src1_renamed),  64'd1);
        chk("young_x5_rob_id",  64'(src1_rob_id),   64'd7);
        chk("young_x5_data",    64'(src1_reg_data), 64'h1234);
        do_retire(4'd7, 5'd5, 32'h5678);
        step();
        idle();

        // Flush beats a same-cycle dispatch; the concurrent retire still lands.
        fetch_redirect_valid = 1'b1;
        do_dispatch(5'd6, 4'd2);
        do_retire(4'd0, 5'd4, 32'h11);
        step();
        idle();
        src1_arf_id = 5'd6;
        src2_arf_id = 5'd4;
        #1;
        chk("flush_x6_renamed", 64'(src1_renamed),  64'd0);
        chk("flush_x4_renamed", 64'(src2_renamed),  64'd0);
        chk("flush_x4_data",    64'(src2_reg_data), 64'h11);
        step();

        // x0 ignores writes and renames.
        do_retire(4'd0, 5'd0, 32'hFFFF);
        do_dispatch(5'd0, 4'd1);
        src1_arf_id = 5'd0;
        step();
        idle();
        #1;
        chk("x0_renamed", 64'(src1_renamed),  64'd0);
        chk("x0_rob_id",  64'(src1_rob_id),   64'd0);
        chk("x0_data",    64'(src1_reg_data), 64'd0);
        step();

        // Same-cycle retire while looking the register up.
        src1_arf_id = 5'd5;
        do_dispatch(5'd5, 4'd3);
        step();
        idle();
        do_retire(4'd3, 5'd5, 32'hBEEF);
        #1;
`ifdef ARF_BYPASS_EN
        chk("byp_x5_renamed", 64'(src1_renamed),  64'd0);
        chk("byp_x5_data",    64'(src1_reg_data), 64'hBEEF);
`else
        chk("nobyp_x5_renamed", 64'(src1_renamed), 64'd1);
        chk("nobyp_x5_rob_id",  64'(src1_rob_id),  64'd3);
`endif
        step();
        idle();
        #1;
        chk("after_byp_x5_data", 64'(src1_reg_data), 64'hBEEF);

        // Dispatch set wins over a retire clear of the same register.
        do_dispatch(5'd9, 4'd4);
        src1_arf_id = 5'd9;
        step();
        do_dispatch(5'd9, 4'd5);
        do_retire(4'd4, 5'd9, 32'h99);
        step();
        idle();
        #1;
        chk("setwin_x9_renamed", 64'(src1_renamed), 64'd1);
        chk("setwin_x9_rob_id",  64'(src1_rob_id),  64'd5);
        step();

        // Randomized traffic over a small register window to force collisions.
        for (int n = 0; n < 400; n++) begin
            arf_id_t ra;
            idle();
            if ($urandom_range(0, 1) == 1) begin
                ra = arf_id_t'($urandom_range(0, 7));
                do_retire(($urandom_range(0, 2) != 0) ? m_rob[ra] : rob_id_t'($urandom_range(0, 15)),
                          ra, reg_data_t'($urandom));
            end
            if ($urandom_range(0, 1) == 1) begin
                dispatch_fire       = 1'b1;
                dispatch_dst_valid  = ($urandom_range(0, 3) != 0);
                dispatch_dst_arf_id = arf_id_t'($urandom_range(0, 7));
                dispatch_rob_id     = rob_id_t'($urandom_range(0, 15));
            end
            fetch_redirect_valid = ($urandom_range(0, 15) == 0);
            src1_arf_id = ($urandom_range(0, 3) == 0) ? retire_arf_id : arf_id_t'($urandom_range(0, 7));
            src2_arf_id = arf_id_t'($urandom_range(0, 7));
            step();
        end

        // Reset asserted in the middle of traffic discards everything.
        do_retire(m_rob[3], 5'd3, 32'hCAFE);
        do_dispatch(5'd2, 4'd6);
        src1_arf_id = 5'd3;
        src2_arf_id = 5'd2;
        #1;
        rst_aL = 1'b0;
        model_reset();
        #1;
        chk("midrst_src1_data",    64'(src1_reg_data), 64'd0);
        chk("midrst_src2_renamed", 64'(src2_renamed),  64'd0);
        @(negedge clk);
        idle();
        rst_aL = 1'b1;
        for (int n = 0; n < 8; n++) begin
            src1_arf_id = arf_id_t'(n);
            src2_arf_id = arf_id_t'(n + 8);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arf.md
ARF -- requirements
Module: arf

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_aL, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port retire, input, 1: ROB head commits this cycle.
REQ-004 SHALL have port retire_rob_id, input, rob_id_t: ROB id of the committing entry.
REQ-005 SHALL have port retire_arf_id, input, arf_id_t: destination architectural register.
REQ-006 SHALL have port retire_reg_data, input, reg_data_t: committed value.
REQ-007 SHALL have port dispatch_fire, input, 1: dispatch handshake completed (valid && ROB/IIQ/LSQ ready).
REQ-008 SHALL have port dispatch_dst_valid, input, 1: the dispatching instruction writes a register.
REQ-009 SHALL have port dispatch_dst_arf_id, input, arf_id_t: dispatched destination.
REQ-010 SHALL have port dispatch_rob_id, input, rob_id_t: ROB id allocated to the dispatched instruction.
REQ-011 SHALL have ports src1_arf_id / src2_arf_id, input, arf_id_t: source lookups.
REQ-012 SHALL have ports src1_renamed / src2_renamed, output, 1: the value is pending in the ROB.
REQ-013 SHALL have ports src1_rob_id / src2_rob_id, output, rob_id_t: ROB id to read when renamed.
REQ-014 SHALL have ports src1_reg_data / src2_reg_data, output, reg_data_t: architectural value when not renamed.
REQ-015 SHALL have port fetch_redirect_valid, input, 1: flush of all speculative state.

Function
REQ-016 SHALL hold ARF_N_ENTRIES (32) data registers plus a rename table of {valid, rob_id} per register.
REQ-017 SHALL drive source lookups combinationally (0-cycle latency) from the registered state; same-cycle dispatch updates SHALL NOT be visible to that cycle's lookups.
REQ-018 SHALL, on retire with retire_arf_id != 0, write retire_reg_data into ARF[retire_arf_id] at the next edge.
REQ-019 SHALL, on retire, clear rename valid for retire_arf_id only if the stored rob_id equals retire_rob_id; a younger mapping SHALL be kept.
REQ-020 SHALL, on dispatch_fire && dispatch_dst_valid && dispatch_dst_arf_id != 0, set the rename entry to {1, dispatch_rob_id}.
REQ-021 SHALL let the dispatch set win over a retire clear on the same arf_id in the same cycle.
REQ-022 SHALL, on fetch_redirect_valid, clear every rename valid bit at the next edge; flush SHALL override a same-cycle dispatch set.
REQ-023 SHALL still perform the ARF data write of a retire that coincides with a flush.
REQ-024 SHALL hard-wire x0: reads return renamed=0, data=0; writes and renames to x0 are ignored.
REQ-025 SHALL drive srcN_rob_id = 0 whenever srcN_renamed = 0.

Reset
REQ-026 SHALL, while rst_aL is low, clear all ARF data to 0 and all rename valid bits to 0 asynchronously; all outputs read renamed=0, data=0.
REQ-027 SHALL discard any retire or dispatch in flight when reset asserts mid-operation.

Configuration
REQ-028 SHALL implement ARF_BYPASS_EN: when defined, a same-cycle retire matching srcN_arf_id (nonzero) and the stored rob_id SHALL yield renamed=0 and data=retire_reg_data combinationally.
REQ-029 SHALL, without ARF_BYPASS_EN, report such a source as renamed with the retiring rob_id; the consumer then reads the ROB.

Structure
REQ-030 SHALL take arf_id_t, rob_id_t, reg_data_t, ARF_N_ENTRIES and ROB_N_ENTRIES from global_defs.svh; a rat_entry_t {valid, rob_id} typedef SHALL be added there.
REQ-031 SHALL place the rename table in one sub-module, rat, with 2 read ports, 1 set port, 1 conditional-clear port and a flush input; the data array SHALL stay in arf.

Verification
REQ-032 SHALL cover: after reset, lookup x5 -> renamed=0, data=0.
REQ-033 SHALL cover: dispatch x5 as rob 3; next cycle lookup x5 -> renamed=1, rob_id=3; retire rob 3, x5, 0xDEAD -> next cycle renamed=0, data=0xDEAD.
REQ-034 SHALL cover: dispatch x5 as rob 3, then x5 as rob 7; retire rob 3 -> x5 stays renamed, rob_id=7, data updated.
REQ-035 SHALL cover: flush in the same cycle as dispatch x6 as rob 2 -> x6 not renamed; a concurrent retire x4=0x11 is still written.
REQ-036 SHALL cover: retire x0=0xFFFF and dispatch x0 -> lookup x0 stays renamed=0, data=0.
REQ-037 SHALL cover: with ARF_BYPASS_EN, retire rob 3, x5, 0xBEEF while looking up x5 -> same-cycle renamed=0, data=0xBEEF; without it -> renamed=1, rob_id=3.
